interval_timer_bank: RTL and testbench
======================================

# interval_timer_bank

Multi-channel, parametrised countdown timer bank for the traffic-light controller; replaces per-phase single timers with one block of CHANNELS independent counters. All channels share one timebase. Each channel loads a per-channel interval on `start`, decrements once per rising edge of the shared `tick`, and emits a one-cycle `expired` pulse when its interval has elapsed. The controller FSM drives `start`/`stop` and consumes `expired`/`remaining`.

## Interface
- CHANNELS, 4: number of independent timer channels (≥1).
- WIDTH, 8: counter and load-value width in bits (≥2).

- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  shared timebase level from the prescaler; only its rising edge counts.
- hold  in  1  global freeze; while 1, tick edges are ignored by all channels.
- start  in  CHANNELS  per-channel load/restart strobe.
- stop  in  CHANNELS  per-channel abort strobe.
- load_val  in  CHANNELS*WIDTH  packed intervals; channel i at [i*WIDTH +: WIDTH].
- running  out  CHANNELS  channel i is counting.
- expired  out  CHANNELS  one-cycle expiry pulse per channel.
- remaining  out  CHANNELS*WIDTH  packed current counts, same packing as load_val.

## Operation
- Shared edge detector: register tick_q <= tick; tick_rise = tick & ~tick_q & ~hold. A tick held high for many cycles gives exactly one tick_rise.
- Per-channel FSM, states IDLE and RUN; running = (state == RUN).
- Per channel, priority highest first:
  - stop[i]: state IDLE, count 0, no expired pulse.
  - start[i] with load_val_i ≠ 0: count <= load_val_i, state RUN (restart if already RUN); any tick_rise that cycle is ignored for this channel.
  - start[i] with load_val_i == 0: state IDLE, count 0, expired[i] pulses next cycle.
  - RUN and tick_rise: if count == 1, count <= 0, expired[i] pulses, state IDLE; else count <= count − 1.
  - otherwise hold.
- An interval of N (1..2^WIDTH−1) expires on the Nth tick_rise after start.
- stop and start in IDLE with no other event: no change. Count never wraps; 0 is only reached on expiry/stop.
- Channels are fully independent; simultaneous events on different channels are all serviced in the same cycle.

## Timing
- Reset (reset_n low, asynchronous): every state IDLE; running 0, expired 0, remaining 0; tick_q 0. Reset mid-count discards the interval with no expiry pulse.
- All outputs are registered.
- start sampled at edge k: running=1 and remaining=load_val from after edge k.
- tick_rise in the cycle before edge k: remaining updates after edge k.
- Expiry: on the edge where count goes 1→0, expired[i]=1 and running[i]=0 for exactly the following cycle; remaining[i]=0.
- Zero-interval start: expired[i]=1 for one cycle after the start edge; running never rises.
- start in the same cycle as an expiring tick_rise: start wins, no expired pulse, count reloaded.
- hold asserted during a tick rising edge: that edge is lost (not deferred).

## Configuration
- Macro INTERVAL_TIMER_AUTO_RELOAD_EN.
- Defined: extra input reload_mode, width CHANNELS. On expiry of channel i with reload_mode[i]=1, expired[i] pulses as usual but the channel stays in RUN with count <= load_val_i as sampled that cycle (load_val_i == 0 reloads as IDLE). stop still ends the period. reload_mode[i]=0 behaves as one-shot.
- Undefined: port absent; all channels strictly one-shot.

## Test plan
- Reset with tick toggling: all outputs 0; release reset, no expired pulses for 20 tick edges with no start.
- CHANNELS=4, WIDTH=8, load_val ch0=3, start[0]; tick high 5 cycles/low 5 cycles: remaining 3,2,1; expired[0] one cycle after 3rd tick edge; running[0] drops same cycle; other channels stay 0.
- ch1 load 5, start; after 2 ticks assert start[1] again: remaining returns to 5, expiry after 5 further ticks; start and stop together on ch2: ch2 IDLE, no pulse.
- ch3 load 0, start: expired[3] one cycle, running[3] 0; ch0 load 1 with start coincident with tick_rise: no decrement, expires on next tick edge.
- hold high across one tick edge with ch0 at 2: remaining stays 2; reset_n low mid-count: immediate running/remaining 0, no expiry.
- With INTERVAL_TIMER_AUTO_RELOAD_EN, reload_mode[0]=1, load 2: expired[0] every 2nd tick edge for 3 periods, running stays 1; stop[0] ends it.

Source files
------------

// File: rtl/interval_timer_bank_if.sv
// Controller-side bus for interval_timer_bank: timebase, per-channel strobes/intervals and status.
// Optional INTERVAL_TIMER_AUTO_RELOAD_EN adds the per-channel reload_mode lane.
interface interval_timer_bank_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
);
   logic                      tick;
   logic                      hold;
   logic [CHANNELS-1:0]       start;
   logic [CHANNELS-1:0]       stop;
   logic [CHANNELS*WIDTH-1:0] load_val;
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
   logic [CHANNELS-1:0]       reload_mode;
`endif
   logic [CHANNELS-1:0]       running;
   logic [CHANNELS-1:0]       expired;
   logic [CHANNELS*WIDTH-1:0] remaining;

   modport master (
      output tick, hold, start, stop, load_val,
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
      output reload_mode,
`endif
      input  running, expired, remaining
   );

   modport slave (
      input  tick, hold, start, stop, load_val,
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
      input  reload_mode,
`endif
      output running, expired, remaining
   );
endinterface

// File: rtl/interval_timer_bank.sv
// Bank of CHANNELS independent countdown timers sharing one edge-detected tick.
// Define INTERVAL_TIMER_AUTO_RELOAD_EN to enable per-channel periodic reload on expiry.
module interval_timer_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   interval_timer_bank_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic                      tick_q_reg;
   logic                      tick_rise;
   logic [CHANNELS-1:0]       running_w;
   logic [CHANNELS-1:0]       expired_w;
   logic [CHANNELS*WIDTH-1:0] remaining_w;

   // tick_q keeps tracking while hold is high, so an edge masked by hold is lost rather than deferred
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tick_q_reg <= 1'b0;
      else          tick_q_reg <= bus.tick;
   end

   assign tick_rise = bus.tick & ~tick_q_reg & ~bus.hold;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         state_t           state_reg, state_next;
         logic [WIDTH-1:0] count_reg, count_next;
         logic             expired_reg, expired_next;
         logic [WIDTH-1:0] lv;
         logic             reload;

         assign lv = bus.load_val[gi*WIDTH +: WIDTH];
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
         assign reload = bus.reload_mode[gi];
`else
         assign reload = 1'b0;
`endif

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               state_reg   <= IDLE;
               count_reg   <= ZERO;
               expired_reg <= 1'b0;
            end else begin
               state_reg   <= state_next;
               count_reg   <= count_next;
               expired_reg <= expired_next;
            end
         end

         always_comb begin
            state_next   = state_reg;
            count_next   = count_reg;
            expired_next = 1'b0;
            if (bus.stop[gi]) begin
               state_next = IDLE;
               count_next = ZERO;
            end else if (bus.start[gi]) begin
               // a zero interval expires immediately without ever entering RUN
               if (lv != ZERO) begin
                  state_next = RUN;
                  count_next = lv;
               end else begin
                  state_next   = IDLE;
                  count_next   = ZERO;
                  expired_next = 1'b1;
               end
            end else if (state_reg == RUN && tick_rise) begin
               if (count_reg == ONE) begin
                  expired_next = 1'b1;
                  if (reload && lv != ZERO) begin
                     state_next = RUN;
                     count_next = lv;
                  end else begin
                     state_next = IDLE;
                     count_next = ZERO;
                  end
               end else begin
                  count_next = count_reg - ONE;
               end
            end
         end

         assign running_w[gi]                   = (state_reg == RUN);
         assign expired_w[gi]                   = expired_reg;
         assign remaining_w[gi*WIDTH +: WIDTH]  = count_reg;
      end
   endgenerate

   assign bus.running   = running_w;
   assign bus.expired   = expired_w;
   assign bus.remaining = remaining_w;
endmodule

// File: tb/tb_interval_timer_bank.sv
// Randomised scoreboard bench for interval_timer_bank against a tick-counting reference model.
module tb_interval_timer_bank;
   localparam int CH = 4;
   localparam int W  = 8;

   typedef struct {
      logic [CH-1:0]   run;
      logic [CH-1:0]   exp;
      logic [CH*W-1:0] rem;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   interval_timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

   interval_timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;
   bit   started  = 0;
   bit   done     = 0;

   // Reference model: each channel tracks whether it is timing and how many tick edges remain
   bit m_active [CH];
   int m_left   [CH];
   bit m_prev_tick;

   function automatic logic [CH*W-1:0] pack(input int a, input int b, input int c, input int d);
      logic [W-1:0] va, vb, vc, vd;
      va = W'(a); vb = W'(b); vc = W'(c); vd = W'(d);
      return {vd, vc, vb, va};
   endfunction

   task automatic step(input bit t, input bit h, input logic [CH-1:0] st, input logic [CH-1:0] sp,
                       input logic [CH*W-1:0] lv, input bit rn, input logic [CH-1:0] rm);
      exp_t e;
      bit   rise;
      int   req;
      @(negedge clk);
      if (!rn && reset_n) begin
         reset_n = 1'b0;
         #1;
         n_checks++;
         if (bus.running !== '0 || bus.remaining !== '0) begin
            n_fail++;
            $display("FAIL async_reset: running=%b remaining=%h, required 0 and 0", bus.running, bus.remaining);
         end
      end
      reset_n  = rn;
      bus.tick = t;
      bus.hold = h;
      bus.start = st;
      bus.stop  = sp;
      bus.load_val = lv;
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
      bus.reload_mode = rm;
`endif
      e.exp = '0;
      if (!rn) begin
         m_prev_tick = 0;
         for (int i = 0; i < CH; i++) begin
            m_active[i] = 0;
            m_left[i]   = 0;
         end
      end else begin
         rise = t && !m_prev_tick && !h;
         m_prev_tick = t;
         for (int i = 0; i < CH; i++) begin
            req = int'(lv[i*W +: W]);
            if (sp[i]) begin
               m_active[i] = 0;
               m_left[i]   = 0;
            end else if (st[i]) begin
               m_active[i] = (req != 0);
               m_left[i]   = req;
               if (req == 0) e.exp[i] = 1'b1;
            end else if (m_active[i] && rise) begin
               m_left[i] = m_left[i] - 1;
               if (m_left[i] == 0) begin
                  e.exp[i] = 1'b1;
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
                  if (rm[i] && req != 0) m_left[i] = req;
                  else                   m_active[i] = 0;
`else
                  m_active[i] = 0;
`endif
               end
            end
         end
      end
      for (int i = 0; i < CH; i++) begin
         e.run[i]        = m_active[i];
         e.rem[i*W +: W] = W'(m_left[i]);
      end
      sb.push_back(e);
      started = 1;
   endtask

   // Monitor: one expected response per clock edge, sampled 1 time unit after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.running !== e.run) begin
               n_fail++;
               $display("FAIL running cycle %0d: got %b, required %b", cycle, bus.running, e.run);
            end
            n_checks++;
            if (bus.expired !== e.exp) begin
               n_fail++;
               $display("FAIL expired cycle %0d: got %b, required %b", cycle, bus.expired, e.exp);
            end
            n_checks++;
            if (bus.remaining !== e.rem) begin
               n_fail++;
               $display("FAIL remaining cycle %0d: got %h, required %h", cycle, bus.remaining, e.rem);
            end
            if (e.exp != '0)
               $display("cycle %0d expiry: expired=%b running=%b remaining=%h", cycle, bus.expired, bus.running, bus.remaining);
         end else if (started && !done) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty cycle %0d: got no expectation, required one", cycle);
         end
      end
   end

   initial begin
      logic [CH*W-1:0] lv;
      logic [CH-1:0]   st, sp, rm;
      bit              t, h, rn;
      int              v [CH];
      bus.tick = 0; bus.hold = 0; bus.start = '0; bus.stop = '0; bus.load_val = '0;
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
      bus.reload_mode = '0;
`endif
      m_prev_tick = 0;
      for (int i = 0; i < CH; i++) begin m_active[i] = 0; m_left[i] = 0; end

      // reset held with tick toggling, then 20 tick edges without any start
      for (int k = 0; k < 6; k++)  step(k[0], 0, '0, '0, '0, 0, '0);
      for (int k = 0; k < 40; k++) step(k[0], 0, '0, '0, '0, 1, '0);

      // ch0 = 3 with tick high 5 / low 5
      lv = pack(3, 0, 0, 0);
      step(0, 0, 4'b0001, '0, lv, 1, '0);
      for (int k = 0; k < 40; k++) step(((k / 5) % 2) == 0, 0, '0, '0, lv, 1, '0);

      // ch1 = 5 restarted after two ticks; ch2 start+stop together
      lv = pack(0, 5, 7, 0);
      step(0, 0, 4'b0110, 4'b0100, lv, 1, '0);
      for (int k = 0; k < 4; k++)  step(k[0], 0, '0, '0, lv, 1, '0);
      step(0, 0, 4'b0010, '0, lv, 1, '0);
      for (int k = 0; k < 14; k++) step(k[0], 0, '0, '0, lv, 1, '0);

      // ch3 zero interval; ch0 = 1 started on a tick rising edge
      lv = pack(1, 0, 0, 0);
      step(0, 0, 4'b1000, '0, lv, 1, '0);
      step(1, 0, 4'b0001, '0, lv, 1, '0);
      for (int k = 0; k < 4; k++)  step(!k[0], 0, '0, '0, lv, 1, '0);

      // hold swallows one tick edge with ch0 at 2, then reset mid-count
      lv = pack(4, 0, 0, 0);
      step(0, 0, 4'b0001, '0, lv, 1, '0);
      step(1, 0, '0, '0, lv, 1, '0);
      step(0, 0, '0, '0, lv, 1, '0);
      step(1, 0, '0, '0, lv, 1, '0);
      step(0, 0, '0, '0, lv, 1, '0);
      step(1, 1, '0, '0, lv, 1, '0);
      step(1, 0, '0, '0, lv, 1, '0);
      step(0, 0, '0, '0, lv, 1, '0);
      step(0, 0, '0, '0, lv, 0, '0);
      step(0, 0, '0, '0, lv, 0, '0);
      step(0, 0, '0, '0, lv, 1, '0);

      // periodic reload on ch0 (reload_mode is only seen when the feature is built in)
      lv = pack(2, 0, 0, 0);
      step(0, 0, 4'b0001, '0, lv, 1, 4'b0001);
      for (int k = 0; k < 14; k++) step(k[0], 0, '0, '0, lv, 1, 4'b0001);
      step(0, 0, '0, 4'b0001, lv, 1, 4'b0001);
      for (int k = 0; k < 6; k++)  step(k[0], 0, '0, '0, lv, 1, 4'b0001);

      // randomised traffic
      t = 0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 2) == 0) t = !t;
         h  = ($urandom_range(0, 9) == 0);
         rn = !(k >= 2000 && k < 2003);
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 9) == 0)       v[i] = 0;
            else if ($urandom_range(0, 49) == 0) v[i] = 255;
            else                                 v[i] = $urandom_range(1, 6);
            st[i] = ($urandom_range(0, 19) == 0);
            sp[i] = ($urandom_range(0, 59) == 0);
            rm[i] = $urandom_range(0, 1);
         end
         lv = pack(v[0], v[1], v[2], v[3]);
         step(t, h, st, sp, lv, rn, rm);
      end

      @(posedge clk); #2;
      done = 1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
